// File: rtl/moore_seq_pkg.sv
// Shared types for the moore_seq_ctrl sequencer: state encoding and the Moore output table.
package moore_seq_pkg;

   typedef enum logic [2:0] {
      S_A = 3'd0,
      S_B = 3'd1,
      S_C = 3'd2,
      S_D = 3'd3,
      S_E = 3'd4,
      S_F = 3'd5,
      S_G = 3'd6,
      S_H = 3'd7
   } state_t;

   // Output table entries are {z1, z2}
   localparam logic [1:0] Z_A = 2'b10;
   localparam logic [1:0] Z_B = 2'b10;
   localparam logic [1:0] Z_C = 2'b10;
   localparam logic [1:0] Z_D = 2'b00;
   localparam logic [1:0] Z_E = 2'b11;
   localparam logic [1:0] Z_F = 2'b10;
   localparam logic [1:0] Z_G = 2'b11;
   localparam logic [1:0] Z_H = 2'b11;

   function automatic logic [1:0] z_of(input state_t s);
      logic [1:0] z;
      case (s)
         S_A:     z = Z_A;
         S_B:     z = Z_B;
         S_C:     z = Z_C;
         S_D:     z = Z_D;
         S_E:     z = Z_E;
         S_F:     z = Z_F;
         S_G:     z = Z_G;
         default: z = Z_H;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/moore_seq_dwell.sv
// Dwell counter for the timed excursion states: synchronous clear, increment enable,
// and a terminal-count flag comparing against the caller-supplied limit.
module moore_seq_dwell #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == limit);

endmodule

// File: rtl/moore_seq_ctrl.sv
// Eight-state Moore sequencer with timed E->F->B and G->H->D excursions.
// Define INPUT_SYNC_EN to pass x and y through 2-flop synchronisers (adds 2 cycles of input latency).
module moore_seq_ctrl
   import moore_seq_pkg::*;
#(
   parameter int T_EF  = 1,
   parameter int T_GH  = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             x,
   input  logic             y,
   output logic             z1,
   output logic             z2,
   output logic [2:0]       state_o,
   output logic             state_chg,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic             err
);

   localparam int T_MAX = (T_EF > T_GH) ? T_EF : T_GH;
   localparam int DW    = $clog2(T_MAX + 1);
   localparam logic [DW-1:0] LIM_EF = DW'(T_EF - 1);
   localparam logic [DW-1:0] LIM_GH = DW'(T_GH - 1);

   state_t        state_q, state_n;
   logic          par_q;
   logic          illegal;
   logic          x_s, y_s;
   logic          dwell_inc, dwell_clr, dwell_tc;
   logic [DW-1:0] dwell_lim;
   logic          cyc_inc;

`ifdef INPUT_SYNC_EN
   logic [1:0] xs_q, ys_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xs_q <= 2'b00;
         ys_q <= 2'b00;
      end else begin
         xs_q <= {xs_q[0], x};
         ys_q <= {ys_q[0], y};
      end
   end

   assign x_s = xs_q[1];
   assign y_s = ys_q[1];
`else
   assign x_s = x;
   assign y_s = y;
`endif

   // Every 3-bit code names a state, so a stored parity bit is what exposes a corrupted register.
   assign illegal = (^state_q) != par_q;

   // en/clr: clr returns to A on the next edge regardless of en; with clr low, en high lets the
   // state, dwell counter and cycle counter advance, en low freezes all three.
   always_comb begin
      state_n   = state_q;
      dwell_inc = 1'b0;
      cyc_inc   = 1'b0;
      if (illegal || clr) begin
         state_n = S_A;
      end else if (en) begin
         case (state_q)
            S_A: if (x_s) state_n = S_B; else if (y_s) state_n = S_E;
            S_B: if (x_s) state_n = S_D;
            S_C: begin
               if (x_s) begin
                  state_n = S_A;
                  cyc_inc = 1'b1;
               end else if (y_s) begin
                  state_n = S_G;
               end
            end
            S_D: if (x_s) state_n = S_C;
            S_E: if (dwell_tc) state_n = S_F; else dwell_inc = 1'b1;
            S_F: if (dwell_tc) state_n = S_B; else dwell_inc = 1'b1;
            S_G: if (dwell_tc) state_n = S_H; else dwell_inc = 1'b1;
            S_H: if (dwell_tc) state_n = S_D; else dwell_inc = 1'b1;
         endcase
      end
   end

   assign dwell_lim = (state_q == S_G || state_q == S_H) ? LIM_GH : LIM_EF;
   assign dwell_clr = clr || illegal || (state_n != state_q);

   moore_seq_dwell #(
      .W (DW)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clr   (dwell_clr),
      .inc   (dwell_inc),
      .limit (dwell_lim),
      .tc    (dwell_tc)
   );

   // Outputs are decoded from the next state so they land in the same cycle as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_A;
         par_q     <= 1'b0;
         z1        <= 1'b1;
         z2        <= 1'b0;
         state_chg <= 1'b0;
         cyc_cnt   <= '0;
         err       <= 1'b0;
      end else begin
         state_q    <= state_n;
         par_q      <= ^state_n;
         {z1, z2}   <= z_of(state_n);
         state_chg  <= (state_n != state_q);
         if (clr) begin
            cyc_cnt <= '0;
         end else if (cyc_inc) begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
         if (illegal) begin
            err <= 1'b1;
         end
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// Bench for moore_seq_ctrl: directed vector table, hand-written timing sequences and a
// randomized run, all compared against a countdown-based reference model.
module tb_moore_seq_ctrl;

   localparam int T_EF  = 3;
   localparam int T_GH  = 4;
   localparam int CNT_W = 8;
`ifdef INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             en = 1'b0;
   logic             clr = 1'b0;
   logic             x = 1'b0;
   logic             y = 1'b0;
   logic             z1, z2;
   logic [2:0]       state_o;
   logic             state_chg;
   logic [CNT_W-1:0] cyc_cnt;
   logic             err;

   int n_chk  = 0;
   int n_fail = 0;

   moore_seq_ctrl #(
      .T_EF  (T_EF),
      .T_GH  (T_GH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .x         (x),
      .y         (y),
      .z1        (z1),
      .z2        (z2),
      .state_o   (state_o),
      .state_chg (state_chg),
      .cyc_cnt   (cyc_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: letter index, remaining dwell cycles, and an input-history queue
   int m_st, m_rem, m_cyc;
   bit m_chg, m_err;
   bit hx[$];
   bit hy[$];
   int z_tab[8]  = '{2, 2, 2, 0, 3, 2, 3, 3};
   int x_next[8] = '{1, 3, 0, 2, 4, 5, 6, 7};
   int succ[8]   = '{0, 1, 2, 3, 5, 1, 7, 3};

   function automatic int dur(input int s);
      return (s == 4 || s == 5) ? T_EF : T_GH;
   endfunction

   task automatic model_reset();
      m_st = 0; m_rem = 0; m_cyc = 0; m_chg = 0; m_err = 0;
      hx.delete(); hy.delete();
      for (int i = 0; i < LAT; i++) begin
         hx.push_back(1'b0);
         hy.push_back(1'b0);
      end
   endtask

   task automatic model_step(input bit e, input bit c, input bit xi, input bit yi);
      int prev;
      bit xe, ye;
      hx.push_back(xi);
      hy.push_back(yi);
      xe = hx[0];
      ye = hy[0];
      void'(hx.pop_front());
      void'(hy.pop_front());
      prev = m_st;
      if (c) begin
         m_st  = 0;
         m_cyc = 0;
      end else if (e) begin
         if (m_st >= 4) begin
            m_rem--;
            if (m_rem == 0) begin
               m_st = succ[m_st];
               if (m_st >= 4) m_rem = dur(m_st);
            end
         end else if (xe) begin
            if (m_st == 2) m_cyc = (m_cyc + 1) % (1 << CNT_W);
            m_st = x_next[m_st];
         end else if (ye && (m_st == 0 || m_st == 2)) begin
            m_st  = (m_st == 0) ? 4 : 6;
            m_rem = dur(m_st);
         end
      end
      m_chg = (m_st != prev);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"}, int'(state_o), m_st);
      check({tag, ".z"}, int'({z1, z2}), z_tab[m_st]);
      check({tag, ".chg"}, int'(state_chg), int'(m_chg));
      check({tag, ".cyc"}, int'(cyc_cnt), m_cyc);
      check({tag, ".err"}, int'(err), int'(m_err));
   endtask

   task automatic tick(input bit e, input bit c, input bit xi, input bit yi);
      en = e; clr = c; x = xi; y = yi;
      @(posedge clk);
      model_step(e, c, xi, yi);
      #1;
      check_all("tick");
   endtask

   // Load the synchroniser with frozen cycles, then one live cycle
   task automatic apply(input bit e, input bit c, input bit xi, input bit yi);
      for (int i = 0; i < LAT; i++) tick(1'b0, 1'b0, xi, yi);
      tick(e, c, xi, yi);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      model_reset();
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Counts cycles spent in state s (already entered), freezing en for frz_n cycles from frz_at
   task automatic dwell_len(input int s, input int frz_at, input int frz_n, output int n);
      int i;
      n = 1;
      i = 0;
      while (int'(state_o) == s && i < 40) begin
         tick(!(i >= frz_at && i < frz_at + frz_n), 1'b0, 1'b0, 1'b0);
         if (int'(state_o) == s) n++;
         i++;
      end
      if (i >= 40) check("dwell_timeout", i, 0);
   endtask

   typedef struct {
      bit en; bit clr; bit x; bit y;
      int st; int z; bit chg; int cyc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit e, input bit c, input bit xi, input bit yi,
                               input int st, input int z, input bit chg);
      vec_t v;
      v.en = e; v.clr = c; v.x = xi; v.y = yi;
      v.st = st; v.z = z; v.chg = chg; v.cyc = 0;
      tbl.push_back(v);
   endfunction

   initial begin
      int n;
      for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 2, 0);
      add(1, 0, 0, 1, 4, 3, 1);
      add(1, 0, 1, 0, 4, 3, 0);
      add(1, 0, 1, 1, 4, 3, 0);
      add(1, 0, 0, 0, 5, 2, 1);
      add(1, 0, 1, 0, 5, 2, 0);
      add(1, 0, 0, 1, 5, 2, 0);
      add(1, 0, 0, 0, 1, 2, 1);
      add(1, 0, 0, 1, 1, 2, 0);
      add(1, 0, 1, 0, 3, 0, 1);
      add(1, 0, 0, 0, 3, 0, 0);
      add(1, 0, 1, 0, 2, 2, 1);
      add(1, 0, 0, 1, 6, 3, 1);
      add(1, 0, 1, 1, 6, 3, 0);
      add(1, 0, 0, 0, 6, 3, 0);
      add(1, 0, 1, 0, 6, 3, 0);
      add(1, 0, 0, 0, 7, 3, 1);
      add(0, 1, 0, 0, 0, 2, 1);
      add(0, 0, 1, 0, 0, 2, 0);

      #1;
      do_reset();

      foreach (tbl[i]) begin
         apply(tbl[i].en, tbl[i].clr, tbl[i].x, tbl[i].y);
         check($sformatf("vec%0d.state", i), int'(state_o), tbl[i].st);
         check($sformatf("vec%0d.z", i), int'({z1, z2}), tbl[i].z);
         check($sformatf("vec%0d.chg", i), int'(state_chg), int'(tbl[i].chg));
         check($sformatf("vec%0d.cyc", i), int'(cyc_cnt), tbl[i].cyc);
      end

      // Counter wrap: 256 full A-B-D-C-A loops
      for (int i = 0; i <= LAT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 1023 + LAT; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
      check("wrap_pre.cyc", int'(cyc_cnt), 255);
      check("wrap_pre.state", int'(state_o), 2);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      check("wrap.cyc", int'(cyc_cnt), 0);
      check("wrap.state", int'(state_o), 0);

      // G dwell with 5 frozen cycles in the middle, then H, then D
      apply(1, 0, 1, 0);
      apply(1, 0, 1, 0);
      apply(1, 0, 1, 0);
      apply(1, 0, 0, 1);
      check("g_entry", int'(state_o), 6);
      dwell_len(6, 1, 5, n);
      check("g_len", n, 9);
      check("g_exit", int'(state_o), 7);
      dwell_len(7, 0, 0, n);
      check("h_len", n, T_GH);
      check("h_exit", int'(state_o), 3);

      // Reset mid-excursion leaves no residual dwell count
      for (int i = 0; i <= LAT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      apply(1, 0, 0, 1);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("e_before_rst", int'(state_o), 4);
      do_reset();
      apply(1, 0, 0, 1);
      check("e_reentry", int'(state_o), 4);
      dwell_len(4, 0, 0, n);
      check("e_len", n, T_EF);

      // Corrupted state register recovers to A and sets the sticky err
      for (int i = 0; i <= LAT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      force dut.par_q = 1'b1;
      m_err = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      release dut.par_q;
      check("illegal.err", int'(err), 1);
      check("illegal.state", int'(state_o), 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("err_sticky", int'(err), 1);
      do_reset();
      check("err_cleared", int'(err), 0);

      // Randomized run against the model
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
